// File: rtl/vector_mac_pkg.sv
// rtl/vector_mac_pkg.sv - shared types and arithmetic helpers for vector_mac_engine (VECTOR_MAC_SATURATE_EN selects saturating output)
package vector_mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT,
        DONE
    } state_t;

    // Wide enough that summing FEATURE_COLS full-scale products cannot overflow.
    function automatic int acc_width(input int feature_w, input int weight_w, input int feature_cols);
        return feature_w + weight_w + $clog2(feature_cols);
    endfunction

    // Reduces an accumulator (zero-extended to 64 bits) to out_w bits; caller truncates the result.
    function automatic logic [63:0] reduce_acc(input logic [63:0] acc, input int out_w);
        logic [63:0] mask;
        mask = (64'd1 << out_w) - 64'd1;
`ifdef VECTOR_MAC_SATURATE_EN
        return ((acc & ~mask) != 64'd0) ? mask : acc;
`else
        return acc & mask;
`endif
    endfunction

endpackage

// File: rtl/vector_mac_engine_if.sv
// rtl/vector_mac_engine_if.sv - memory read ports and result-row handshake of vector_mac_engine
interface vector_mac_engine_if #(
    parameter int FEATURE_WIDTH = 8,
    parameter int WEIGHT_WIDTH  = 5,
    parameter int FEATURE_COLS  = 96,
    parameter int WEIGHT_ROWS   = 96,
    parameter int FEATURE_ROWS  = 6,
    parameter int WEIGHT_COLS   = 3,
    parameter int OUT_WIDTH     = 16
);
    logic                                 feat_rd_en;
    logic [$clog2(FEATURE_ROWS)-1:0]      feat_rd_row;
    logic [$clog2(FEATURE_COLS)-1:0]      feat_rd_col;
    logic [FEATURE_WIDTH-1:0]             feat_rd_data;
    logic                                 wgt_rd_en;
    logic [$clog2(WEIGHT_ROWS)-1:0]       wgt_rd_addr;
    logic [WEIGHT_COLS*WEIGHT_WIDTH-1:0]  wgt_rd_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [$clog2(FEATURE_ROWS)-1:0]      out_row;
    logic [WEIGHT_COLS*OUT_WIDTH-1:0]     out_data;

    modport master (
        output feat_rd_en, feat_rd_row, feat_rd_col,
        input  feat_rd_data,
        output wgt_rd_en, wgt_rd_addr,
        input  wgt_rd_data,
        output out_valid, out_row, out_data,
        input  out_ready
    );

    modport slave (
        input  feat_rd_en, feat_rd_row, feat_rd_col,
        output feat_rd_data,
        input  wgt_rd_en, wgt_rd_addr,
        output wgt_rd_data,
        input  out_valid, out_row, out_data,
        output out_ready
    );
endinterface

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one unsigned multiply-accumulate lane (one output column)
module mac_lane #(
    parameter int FEATURE_WIDTH = 8,
    parameter int WEIGHT_WIDTH  = 5,
    parameter int ACC_W         = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     acc_en,
    input  logic [FEATURE_WIDTH-1:0] feature,
    input  logic [WEIGHT_WIDTH-1:0]  weight,
    output logic [ACC_W-1:0]         acc
);
    localparam int PROD_W = FEATURE_WIDTH + WEIGHT_WIDTH;

    logic [PROD_W-1:0] prod;

    assign prod = {{WEIGHT_WIDTH{1'b0}}, feature} * {{FEATURE_WIDTH{1'b0}}, weight};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_en) begin
            // load starts a fresh row so no separate clear cycle is needed
            acc <= load ? ACC_W'(prod) : acc + ACC_W'(prod);
        end
    end
endmodule

// File: rtl/vector_mac_engine.sv
// rtl/vector_mac_engine.sv - sequential FEAT x WGT matrix product, one result row per handshake
module vector_mac_engine #(
    parameter int WEIGHT_WIDTH  = 5,
    parameter int FEATURE_WIDTH = 8,
    parameter int FEATURE_COLS  = 96,
    parameter int WEIGHT_ROWS   = 96,
    parameter int FEATURE_ROWS  = 6,
    parameter int WEIGHT_COLS   = 3,
    parameter int OUT_WIDTH     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    vector_mac_engine_if.master bus
);
    import vector_mac_pkg::*;

    localparam int ACC_W = acc_width(FEATURE_WIDTH, WEIGHT_WIDTH, FEATURE_COLS);
    localparam int KW    = $clog2(FEATURE_COLS);
    localparam int RW    = $clog2(FEATURE_ROWS);
    localparam logic [KW-1:0] K_LAST = KW'(FEATURE_COLS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(FEATURE_ROWS - 1);

    state_t          state;
    logic [RW-1:0]   r;
    logic [KW-1:0]   k;
    logic            rd_en;
    logic            out_valid;
    logic            acc_en_q;
    logic            load_q;
    logic [ACC_W-1:0] lane_acc [WEIGHT_COLS];
    logic [WEIGHT_COLS*OUT_WIDTH-1:0] out_data_w;

    assert property (@(posedge clk) FEATURE_COLS == WEIGHT_ROWS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r         <= '0;
            k         <= '0;
            rd_en     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc_en_q  <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            // memory returns data one cycle after the strobe, so the lanes trail the address by one
            acc_en_q <= rd_en;
            load_q   <= rd_en && (k == '0);
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        r     <= '0;
                        k     <= '0;
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (r == R_LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            r     <= r + 1'b1;
                            k     <= '0;
                            rd_en <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_lane
        mac_lane #(
            .FEATURE_WIDTH (FEATURE_WIDTH),
            .WEIGHT_WIDTH  (WEIGHT_WIDTH),
            .ACC_W         (ACC_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (load_q),
            .acc_en  (acc_en_q),
            .feature (bus.feat_rd_data),
            .weight  (bus.wgt_rd_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .acc     (lane_acc[c])
        );

        // accumulators are frozen outside RUN/DRAIN, so this holds steady through OUT stalls
        assign out_data_w[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(reduce_acc(64'(lane_acc[c]), OUT_WIDTH));
    end

    assign bus.feat_rd_en  = rd_en;
    assign bus.feat_rd_row = r;
    assign bus.feat_rd_col = k;
    assign bus.wgt_rd_en   = rd_en;
    assign bus.wgt_rd_addr = k;
    assign bus.out_valid   = out_valid;
    assign bus.out_row     = r;
    assign bus.out_data    = out_data_w;
endmodule

// File: tb/tb_vector_mac_engine.sv
// tb/tb_vector_mac_engine.sv - directed self-checking bench for vector_mac_engine
module tb_vector_mac_engine;

`ifdef VECTOR_MAC_SATURATE_EN
    localparam int D_EXP = 65535;
`else
    localparam int D_EXP = 37984;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic s_reset, s_start, s_busy, s_done;
    logic d_reset, d_start, d_busy, d_done;

    int n_checks = 0;
    int n_fail   = 0;

    vector_mac_engine_if #(.FEATURE_WIDTH(8), .WEIGHT_WIDTH(5), .FEATURE_COLS(4), .WEIGHT_ROWS(4),
                           .FEATURE_ROWS(2), .WEIGHT_COLS(3), .OUT_WIDTH(16)) sif ();
    vector_mac_engine_if #(.FEATURE_WIDTH(8), .WEIGHT_WIDTH(5), .FEATURE_COLS(96), .WEIGHT_ROWS(96),
                           .FEATURE_ROWS(6), .WEIGHT_COLS(3), .OUT_WIDTH(16)) dif ();

    vector_mac_engine #(.WEIGHT_WIDTH(5), .FEATURE_WIDTH(8), .FEATURE_COLS(4), .WEIGHT_ROWS(4),
                        .FEATURE_ROWS(2), .WEIGHT_COLS(3), .OUT_WIDTH(16)) u_small (
        .clk   (clk),
        .reset (s_reset),
        .start (s_start),
        .busy  (s_busy),
        .done  (s_done),
        .bus   (sif.master)
    );

    vector_mac_engine #(.WEIGHT_WIDTH(5), .FEATURE_WIDTH(8), .FEATURE_COLS(96), .WEIGHT_ROWS(96),
                        .FEATURE_ROWS(6), .WEIGHT_COLS(3), .OUT_WIDTH(16)) u_dflt (
        .clk   (clk),
        .reset (d_reset),
        .start (d_start),
        .busy  (d_busy),
        .done  (d_done),
        .bus   (dif.master)
    );

    logic [7:0]  s_feat [2][4];
    logic [14:0] s_wgt  [4];
    logic [7:0]  d_feat [6][96];
    logic [14:0] d_wgt  [96];

    always @(posedge clk) begin
        if (sif.feat_rd_en) sif.feat_rd_data <= s_feat[sif.feat_rd_row][sif.feat_rd_col];
        if (sif.wgt_rd_en)  sif.wgt_rd_data  <= s_wgt[sif.wgt_rd_addr];
        if (dif.feat_rd_en) dif.feat_rd_data <= d_feat[dif.feat_rd_row][dif.feat_rd_col];
        if (dif.wgt_rd_en)  dif.wgt_rd_data  <= d_wgt[dif.wgt_rd_addr];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int s_lane(input int c);
        return int'(sif.out_data[c*16 +: 16]);
    endfunction

    function automatic int d_lane(input int c);
        return int'(dif.out_data[c*16 +: 16]);
    endfunction

    task automatic load_ones();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) s_feat[r][k] = 8'd1;
        for (int k = 0; k < 4; k++) s_wgt[k] = {5'd3, 5'd2, 5'd1};
    endtask

    task automatic load_ramp();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) s_feat[r][k] = 8'(k + 1 + r);
        for (int k = 0; k < 4; k++) s_wgt[k] = {5'd1, 5'd1, 5'd1};
    endtask

    task automatic s_check_idle(input string tag);
        check({tag, "_busy"}, s_busy, 0);
        check({tag, "_done"}, s_done, 0);
        check({tag, "_feat_en"}, sif.feat_rd_en, 0);
        check({tag, "_wgt_en"}, sif.wgt_rd_en, 0);
        check({tag, "_addr"}, {sif.feat_rd_row, sif.feat_rd_col, sif.wgt_rd_addr}, 0);
        check({tag, "_valid"}, sif.out_valid, 0);
        check({tag, "_row"}, sif.out_row, 0);
        check({tag, "_data"}, sif.out_data, 0);
    endtask

    // one negedge has already elapsed since the row started (start or handshake)
    task automatic s_row(input string tag, input int row, input int e0, input int e1, input int e2);
        int n = 1;
        while (sif.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 6);
        check({tag, "_row"}, sif.out_row, row);
        check({tag, "_l0"}, s_lane(0), e0);
        check({tag, "_l1"}, s_lane(1), e1);
        check({tag, "_l2"}, s_lane(2), e2);
    endtask

    task automatic s_go();
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic s_accept();
        sif.out_ready = 1'b1;
        @(negedge clk);
        sif.out_ready = 1'b0;
    endtask

    task automatic s_finish_pass(input string tag);
        s_accept();
        check({tag, "_done_pulse"}, s_done, 1);
        @(negedge clk);
        check({tag, "_done_end"}, s_done, 0);
        check({tag, "_idle"}, s_busy, 0);
    endtask

    initial begin
        int rd_seen;
        int unstable;
        int done_seen;
        int n;

        s_reset = 1'b1; d_reset = 1'b1;
        s_start = 1'b0; d_start = 1'b0;
        sif.out_ready = 1'b0;
        dif.out_ready = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 96; k++) d_feat[r][k] = 8'd255;
        for (int k = 0; k < 96; k++) d_wgt[k] = {5'd31, 5'd31, 5'd31};
        repeat (3) @(negedge clk);
        s_check_idle("rst");
        check("rst_d_busy", d_busy, 0);
        check("rst_d_data", dif.out_data, 0);
        s_reset = 1'b0; d_reset = 1'b0;
        @(negedge clk);

        // all-ones features, weight column c = c+1
        load_ones();
        s_go();
        s_row("ones_r0", 0, 4, 8, 12);
        s_accept();
        s_row("ones_r1", 1, 4, 8, 12);
        s_finish_pass("ones");

        // ramp features, unit weights, with a 20-cycle stall and a stray start
        load_ramp();
        s_go();
        s_row("ramp_r0", 0, 10, 10, 10);
        rd_seen = 0;
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            s_start = (i == 5);
            @(negedge clk);
            if (sif.feat_rd_en || sif.wgt_rd_en) rd_seen++;
            if (sif.out_valid !== 1'b1 || sif.out_row !== 1'b0 ||
                s_lane(0) != 10 || s_lane(1) != 10 || s_lane(2) != 10) unstable++;
        end
        s_start = 1'b0;
        check("stall_rd_en", rd_seen, 0);
        check("stall_stable", unstable, 0);
        check("stall_busy", s_busy, 1);
        s_accept();
        s_row("ramp_r1", 1, 14, 14, 14);
        s_finish_pass("ramp");

        // reset in the middle of row 1, then a clean pass
        load_ones();
        s_go();
        s_row("rst_run_r0", 0, 4, 8, 12);
        s_accept();
        @(negedge clk);
        check("rst_run_in_run", sif.feat_rd_en, 1);
        s_reset = 1'b1;
        @(negedge clk);
        s_check_idle("rst_run");
        s_reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_done) done_seen++;
        end
        check("rst_run_no_done", done_seen, 0);
        load_ramp();
        s_go();
        s_row("rerun_r0", 0, 10, 10, 10);
        s_accept();
        s_row("rerun_r1", 1, 14, 14, 14);
        s_finish_pass("rerun");

        // default geometry at full scale
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        for (int r = 0; r < 6; r++) begin
            n = 1;
            while (dif.out_valid !== 1'b1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("full_r%0d_lat", r), n, 98);
            check($sformatf("full_r%0d_row", r), dif.out_row, r);
            for (int c = 0; c < 3; c++)
                check($sformatf("full_r%0d_l%0d", r, c), d_lane(c), D_EXP);
            dif.out_ready = 1'b1;
            @(negedge clk);
            dif.out_ready = 1'b0;
        end
        check("full_done", d_done, 1);
        @(negedge clk);
        check("full_idle", d_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
